// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load queue entry type and default depth constants
package lsu_pkg;

   localparam int LDQ_ENTRIES_DEF = 8;
   localparam int SDQ_ENTRIES_DEF = 8;
   localparam int ADDR_W_DEF      = 32;
   localparam int SDQ_MARK_W      = $clog2(SDQ_ENTRIES_DEF) + 1;

   // Entry fields are sized by the package defaults; the queue parameters default to the same values
   typedef struct packed {
      logic                  valid;
      logic                  addr_valid;
      logic                  issued;
      logic                  done;
      logic [ADDR_W_DEF-1:0] addr;
      logic [SDQ_MARK_W-1:0] sdq_marker;
   } ldq_entry_t;

endpackage

// File: rtl/ldq_age_picker.sv
// rtl/ldq_age_picker.sv - oldest eligible slot finder, scanning from head with wrap
module ldq_age_picker #(
   parameter int N = 8
) (
   input  logic [N-1:0]         elig,
   input  logic [$clog2(N)-1:0] head,
   output logic                 vld,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] cand;

   // Walk offsets from youngest to oldest so the slot nearest head wins last
   always_comb begin
      vld  = 1'b0;
      idx  = head;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = head + IW'(k);
         if (elig[cand]) begin
            vld = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/load_queue.sv
// rtl/load_queue.sv - age-ordered circular load queue; replay enabled by LDQ_REPLAY_EN
module load_queue
   import lsu_pkg::*;
#(
   parameter int LDQ_ENTRIES = LDQ_ENTRIES_DEF,
   parameter int SDQ_ENTRIES = SDQ_ENTRIES_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           disp_vld,
   input  logic [$clog2(SDQ_ENTRIES):0]   disp_sdq_marker,
   output logic [$clog2(LDQ_ENTRIES)-1:0] disp_ldq_idx,
   output logic                           disp_full,
   input  logic                           exec_vld,
   input  logic [$clog2(LDQ_ENTRIES)-1:0] exec_ldq_idx,
   input  logic [ADDR_W-1:0]              exec_addr,
   output logic                           issue_vld,
   input  logic                           issue_rdy,
   output logic [$clog2(LDQ_ENTRIES)-1:0] issue_idx,
   output ldq_entry_t                     issue_entry,
   input  logic                           cmpl_vld,
   input  logic [$clog2(LDQ_ENTRIES)-1:0] cmpl_idx,
   input  logic                           replay_vld,
   input  logic [$clog2(LDQ_ENTRIES)-1:0] replay_idx,
   input  logic                           flush,
   output logic [$clog2(LDQ_ENTRIES):0]   count
);

   localparam int IW = $clog2(LDQ_ENTRIES);
   localparam int PW = IW + 1;

   ldq_entry_t             q [LDQ_ENTRIES];
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [IW-1:0]          head_idx;
   logic [IW-1:0]          tail_idx;
   logic [LDQ_ENTRIES-1:0] elig;
   logic                   alloc;
   logic                   retire;
   logic                   issue_fire;

`ifndef LDQ_REPLAY_EN
   logic unused_replay;
   assign unused_replay = ^{replay_vld, replay_idx};
`endif

   assign head_idx     = head[IW-1:0];
   assign tail_idx     = tail[IW-1:0];
   assign count        = tail - head;
   assign disp_full    = (count == PW'(LDQ_ENTRIES));
   assign disp_ldq_idx = tail_idx;
   assign alloc        = disp_vld & ~disp_full;
   assign retire       = q[head_idx].valid & q[head_idx].done;
   assign issue_fire   = issue_vld & issue_rdy;
   assign issue_entry  = q[issue_idx];

   // Eligibility: address known and not yet sent or finished
   always_comb begin
      elig = '0;
      for (int i = 0; i < LDQ_ENTRIES; i++) begin
         elig[i] = q[i].valid & q[i].addr_valid & ~q[i].issued & ~q[i].done;
      end
   end

   ldq_age_picker #(.N(LDQ_ENTRIES)) u_picker (
      .elig (elig),
      .head (head_idx),
      .vld  (issue_vld),
      .idx  (issue_idx)
   );

   // Queue state: flush beats everything; replay is ordered after completion so it wins on the same slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         for (int i = 0; i < LDQ_ENTRIES; i++) q[i] <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         for (int i = 0; i < LDQ_ENTRIES; i++) q[i] <= '0;
      end else begin
         if (exec_vld && q[exec_ldq_idx].valid) begin
            q[exec_ldq_idx].addr       <= exec_addr;
            q[exec_ldq_idx].addr_valid <= 1'b1;
         end
         if (issue_fire) begin
            q[issue_idx].issued <= 1'b1;
         end
         if (cmpl_vld && q[cmpl_idx].valid && q[cmpl_idx].issued) begin
            q[cmpl_idx].done <= 1'b1;
         end
`ifdef LDQ_REPLAY_EN
         if (replay_vld && q[replay_idx].valid) begin
            q[replay_idx].issued <= 1'b0;
            q[replay_idx].done   <= 1'b0;
         end
`endif
         if (retire) begin
            q[head_idx].valid <= 1'b0;
            head              <= head + 1'b1;
         end
         if (alloc) begin
            q[tail_idx] <= '{valid: 1'b1, addr_valid: 1'b0, issued: 1'b0, done: 1'b0,
                             addr: '0, sdq_marker: disp_sdq_marker};
            tail        <= tail + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_load_queue.sv
// tb/tb_load_queue.sv - directed table-driven bench for load_queue
module tb_load_queue;
   import lsu_pkg::*;

`ifdef LDQ_REPLAY_EN
   localparam logic REPLAY_ON = 1'b1;
`else
   localparam logic REPLAY_ON = 1'b0;
`endif

   typedef struct {
      logic        dv;
      logic [3:0]  mk;
      logic        ev;
      logic [2:0]  ei;
      logic [31:0] ea;
      logic        rdy;
      logic        cv;
      logic [2:0]  ci;
      logic        fl;
      logic [3:0]  cnt;
      logic        full;
      logic        ivld;
      logic [2:0]  iidx;
      logic [31:0] iaddr;
      logic [3:0]  imk;
      logic [2:0]  didx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_vld;
   logic [3:0]  disp_sdq_marker;
   logic [2:0]  disp_ldq_idx;
   logic        disp_full;
   logic        exec_vld;
   logic [2:0]  exec_ldq_idx;
   logic [31:0] exec_addr;
   logic        issue_vld;
   logic        issue_rdy;
   logic [2:0]  issue_idx;
   ldq_entry_t  issue_entry;
   logic        cmpl_vld;
   logic [2:0]  cmpl_idx;
   logic        replay_vld;
   logic [2:0]  replay_idx;
   logic        flush;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   load_queue dut (
      .clk(clk), .rst(rst),
      .disp_vld(disp_vld), .disp_sdq_marker(disp_sdq_marker),
      .disp_ldq_idx(disp_ldq_idx), .disp_full(disp_full),
      .exec_vld(exec_vld), .exec_ldq_idx(exec_ldq_idx), .exec_addr(exec_addr),
      .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_idx(issue_idx),
      .issue_entry(issue_entry),
      .cmpl_vld(cmpl_vld), .cmpl_idx(cmpl_idx),
      .replay_vld(replay_vld), .replay_idx(replay_idx),
      .flush(flush), .count(count)
   );

   function automatic vec_t v(input logic dv, input logic [3:0] mk, input logic ev,
                              input logic [2:0] ei, input logic [31:0] ea, input logic rdy,
                              input logic cv, input logic [2:0] ci, input logic fl,
                              input logic [3:0] cnt, input logic full, input logic ivld,
                              input logic [2:0] iidx, input logic [31:0] iaddr,
                              input logic [3:0] imk, input logic [2:0] didx);
      vec_t r;
      r.dv = dv; r.mk = mk; r.ev = ev; r.ei = ei; r.ea = ea; r.rdy = rdy;
      r.cv = cv; r.ci = ci; r.fl = fl; r.cnt = cnt; r.full = full; r.ivld = ivld;
      r.iidx = iidx; r.iaddr = iaddr; r.imk = imk; r.didx = didx;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      disp_vld = t.dv; disp_sdq_marker = t.mk;
      exec_vld = t.ev; exec_ldq_idx = t.ei; exec_addr = t.ea;
      issue_rdy = t.rdy; cmpl_vld = t.cv; cmpl_idx = t.ci; flush = t.fl;
      @(posedge clk);
      #1;
      chk({tag, " count"}, 32'(count), 32'(t.cnt));
      chk({tag, " full"}, 32'(disp_full), 32'(t.full));
      chk({tag, " issue_vld"}, 32'(issue_vld), 32'(t.ivld));
      chk({tag, " disp_idx"}, 32'(disp_ldq_idx), 32'(t.didx));
      if (t.ivld) begin
         chk({tag, " issue_idx"}, 32'(issue_idx), 32'(t.iidx));
         chk({tag, " issue_addr"}, issue_entry.addr, t.iaddr);
         chk({tag, " issue_mk"}, 32'(issue_entry.sdq_marker), 32'(t.imk));
      end
   endtask

   // Stimulus: vector table first, then hand sequences for replay and reset abort
   initial begin
      rst = 1'b0; disp_vld = 0; disp_sdq_marker = 0; exec_vld = 0; exec_ldq_idx = 0;
      exec_addr = 0; issue_rdy = 0; cmpl_vld = 0; cmpl_idx = 0; replay_vld = 0;
      replay_idx = 0; flush = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset count", 32'(count), 32'd0);
      chk("reset full", 32'(disp_full), 32'd0);
      chk("reset issue_vld", 32'(issue_vld), 32'd0);
      chk("reset disp_idx", 32'(disp_ldq_idx), 32'd0);
      rst = 1'b1;

      // Fill to full, ninth dispatch ignored, flush
      for (int k = 0; k < 8; k++)
         tbl.push_back(v(1, 4'(k), 0, 0, 0, 0, 0, 0, 0, 4'(k + 1), k == 7, 0, 0, 0, 0, 3'(k + 1)));
      tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      // Oldest-first offer, stall stability, out-of-order completion
      tbl.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 6, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 2));
      tbl.push_back(v(1, 7, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 1, 2, 32'h200, 0, 0, 0, 0, 3, 0, 1, 2, 32'h200, 7, 3));
      tbl.push_back(v(0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 3, 0, 1, 0, 32'h100, 5, 3));
      for (int k = 0; k < 3; k++)
         tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 32'h100, 5, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 1, 2, 32'h200, 7, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 1, 1, 32'h180, 0, 0, 0, 0, 3, 0, 1, 1, 32'h180, 6, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
      // Wrap: fill, retire three, reallocate, age order across the wrap
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(v(1, 4'(k), 0, 0, 0, 0, 0, 0, 0, 4'(k + 1), k == 7, 0, 0, 0, 0, 3'(k + 1)));
      tbl.push_back(v(0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 8, 1, 1, 0, 32'h10, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h11, 1, 0, 0, 0, 8, 1, 1, 1, 32'h11, 1, 0));
      tbl.push_back(v(0, 0, 1, 2, 32'h12, 1, 0, 0, 0, 8, 1, 1, 2, 32'h12, 2, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 2, 0, 6, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 9, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 10, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2));
      tbl.push_back(v(1, 11, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 3));
      tbl.push_back(v(0, 0, 1, 0, 32'hA0, 0, 0, 0, 0, 8, 1, 1, 0, 32'hA0, 9, 3));
      tbl.push_back(v(0, 0, 1, 7, 32'h70, 0, 0, 0, 0, 8, 1, 1, 7, 32'h70, 7, 3));
      tbl.push_back(v(0, 0, 1, 3, 32'h30, 0, 0, 0, 0, 8, 1, 1, 3, 32'h30, 3, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1, 1, 7, 32'h70, 7, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1, 1, 0, 32'hA0, 9, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 3));
      // Flush beats same-cycle alloc/exec/cmpl; exec to an empty slot ignored
      tbl.push_back(v(1, 1, 1, 4, 32'h44, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // Replay of an issued slot, and replay against completion on the same slot
      for (int k = 0; k < 5; k++)
         step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'(k + 1), 0, 0, 0, 0, 0, 3'(k + 1)), "rp_alloc");
      step(v(0, 0, 1, 4, 32'h40, 0, 0, 0, 0, 5, 0, 1, 4, 32'h40, 0, 5), "rp_exec");
      step(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5), "rp_issue");
      replay_vld = 1'b1; replay_idx = 3'd4;
      step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, REPLAY_ON, 4, 32'h40, 0, 5), "rp_replay");
      replay_vld = 1'b0;
      step(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5), "rp_reissue");
      replay_vld = 1'b1;
      step(v(0, 0, 0, 0, 0, 0, 1, 4, 0, 5, 0, REPLAY_ON, 4, 32'h40, 0, 5), "rp_vs_cmpl");
      replay_vld = 1'b0;
      step(v(0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 5, 0, 1, 3, 32'h33, 0, 5), "abort_offer");

      // Reset in the middle of an offered, unaccepted handshake
      #2;
      rst = 1'b0;
      #1;
      chk("abort issue_vld", 32'(issue_vld), 32'd0);
      chk("abort count", 32'(count), 32'd0);
      chk("abort disp_idx", 32'(disp_ldq_idx), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_queue.md
LOAD_QUEUE -- requirements
Module: load_queue

Interface
REQ-001 SHALL have parameter LDQ_ENTRIES, default 8, queue depth (power of two, >=2).
REQ-002 SHALL have parameter SDQ_ENTRIES, default 8, store queue depth (sizes sdq_marker).
REQ-003 SHALL have parameter ADDR_W, default 32, load address width.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  disp_vld  in  1  allocate request
  disp_sdq_marker  in  $clog2(SDQ_ENTRIES)+1  youngest older store tag
  disp_ldq_idx  out  $clog2(LDQ_ENTRIES)  allocated slot (tail)
  disp_full  out  1  no free slot
  exec_vld  in  1  address update
  exec_ldq_idx  in  $clog2(LDQ_ENTRIES)  target slot
  exec_addr  in  ADDR_W  load address
  issue_vld  out  1  entry offered to LSU
  issue_rdy  in  1  LSU accepts
  issue_idx  out  $clog2(LDQ_ENTRIES)  offered slot
  issue_entry  out  ldq_entry_t  offered entry contents
  cmpl_vld  in  1  load data returned
  cmpl_idx  in  $clog2(LDQ_ENTRIES)  completed slot
  replay_vld  in  1  reissue request (LDQ_REPLAY_EN only)
  replay_idx  in  $clog2(LDQ_ENTRIES)  slot to replay
  flush  in  1  discard all entries
  count  out  $clog2(LDQ_ENTRIES)+1  occupied entries

Function
REQ-005 Queue SHALL be circular, age-ordered: head/tail pointers each with one extra wrap bit.
REQ-006 Allocation SHALL occur when disp_vld & ~disp_full: slot tail written valid=1, addr_valid=0, issued=0, done=0, addr=0, marker=disp_sdq_marker; tail increments with wrap.
REQ-007 disp_full SHALL be (count==LDQ_ENTRIES) from registered state; retirement in same cycle SHALL NOT unblock allocation.
REQ-008 exec_vld SHALL set addr and addr_valid of exec_ldq_idx at next edge; writes to invalid slots SHALL be ignored.
REQ-009 An entry SHALL be eligible when valid & addr_valid & ~issued & ~done.
REQ-010 issue_vld/issue_idx/issue_entry SHALL select the oldest eligible entry (nearest head, wrap-aware), combinationally from registered state.
REQ-011 Handshake: on issue_vld & issue_rdy, selected entry SHALL set issued=1; issue_entry SHALL remain stable while issue_vld & ~issue_rdy unless flush.
REQ-012 Entry allocated or address-written in cycle N SHALL be issuable no earlier than N+1.
REQ-013 cmpl_vld SHALL set done on cmpl_idx if valid & issued; otherwise ignored.
REQ-014 Head entry SHALL retire (valid=0, head++) when valid & done; at most one retire per cycle.
REQ-015 count SHALL equal tail-head (wrap-aware); alloc and retire in same cycle SHALL leave count unchanged.
REQ-016 flush SHALL have priority over all other inputs: next edge clears all valid bits, head=tail=0, count=0.

Reset
REQ-017 While rst low: all entries zeroed, head=tail=0, count=0, disp_full=0, issue_vld=0, disp_ldq_idx=0.
REQ-018 Reset asserted mid-handshake SHALL abort it with no state retained.

Configuration
REQ-019 With LDQ_REPLAY_EN defined, replay_vld SHALL clear issued and done of replay_idx (if valid), making it eligible again next cycle; replay takes priority over cmpl_vld on the same slot.
REQ-020 Without LDQ_REPLAY_EN, replay ports SHALL exist but be ignored, and entries issue exactly once.

Structure
REQ-021 ldq_entry_t (valid, addr_valid, issued, done, addr, sdq_marker) and depth constants SHALL reside in lsu_pkg.
REQ-022 Oldest-eligible selection SHALL be a sub-module ldq_age_picker (eligibility vector, head pointer -> valid, index).

Verification
REQ-023 Reset, 8 allocs -> idx 0..7, disp_full=1 after 8th; 9th disp_vld ignored, count=8.
REQ-024 Alloc 0,1,2; addr to 2 then 0 -> issue_idx=0 first, then 2; slot 1 never offered.
REQ-025 issue_rdy=0 for 3 cycles -> issue_idx/issue_entry stable; rdy=1 -> issued set, next candidate offered.
REQ-026 Complete slot 1 before slot 0 -> no retire until slot 0 done, then two retires on consecutive cycles, count 3->1.
REQ-027 Fill, retire 3, allocate 3 -> indices 0,1,2 reused via wrap; oldest-first issue still honours age across wrap.
REQ-028 flush with alloc, exec, cmpl same cycle -> count=0, issue_vld=0 next cycle; with LDQ_REPLAY_EN, replay of issued slot 4 -> reoffered next cycle.
